div: RTL

DIV -- requirements
Module: div

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_if.sv | 22 ++
 rtl/div.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants, state encodings and helpers for the iterative 32-bit divider.
package div_pkg;

   localparam logic RstEnable         = 1'b1;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

   // One restoring step per quotient bit; the counter value 32 marks the correction cycle.
   localparam logic [5:0] IterCount = 6'd32;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   function automatic logic [31:0] magnitude(input logic [31:0] value, input logic as_signed);
      return (as_signed && value[31]) ? (~value + 32'd1) : value;
   endfunction

endpackage

// File: rtl/div_if.sv
// Request/result bundle between the execute stage (master) and the divider (slave).
interface div_if;

   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );

endinterface

// File: rtl/div.sv
// Iterative restoring divider, 32 cycles plus one sign-correction cycle per operation.
// Build option: define DIV_ZERO_DETECT_EN to short-circuit a zero divisor into a zero result.
module div
   import div_pkg::*;
(
   input logic  clk,
   input logic  rst,
   div_if.slave bus
);

   div_state_e  state;
   div_state_e  state_next;
   logic [5:0]  cnt;
   logic [31:0] quo_reg;
   logic [31:0] rem_reg;
   logic [31:0] divisor_reg;
   logic        signed_reg;
   logic        op1_neg;
   logic        op2_neg;
   logic [63:0] result_reg;
   logic        ready_d;
   logic [63:0] result_d;
   logic        ready_q;
   logic [63:0] result_q;

   logic        accept;
   logic [31:0] partial;
   logic [32:0] diff;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   assign accept  = (bus.start_i == DivStart) && !bus.annul_i;
   assign partial = {rem_reg[30:0], quo_reg[31]};
   assign diff    = {1'b0, partial} - {1'b0, divisor_reg};
   assign quo_fix = (signed_reg && (op1_neg ^ op2_neg)) ? (~quo_reg + 32'd1) : quo_reg;
   assign rem_fix = (signed_reg && op1_neg) ? (~rem_reg + 32'd1) : rem_reg;

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state <= DivFree;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         DivFree: begin
            if (accept) begin
`ifdef DIV_ZERO_DETECT_EN
               state_next = (bus.opdata2_i == 32'd0) ? DivByZero : DivOn;
`else
               state_next = DivOn;
`endif
            end
         end
         DivByZero: state_next = bus.annul_i ? DivFree : DivEnd;
         DivOn: begin
            if (bus.annul_i) begin
               state_next = DivFree;
            end else if (cnt == IterCount) begin
               state_next = DivEnd;
            end
         end
         DivEnd:  state_next = (bus.start_i == DivStop) ? DivFree : DivEnd;
         default: state_next = DivFree;
      endcase
   end

   // Outputs are registered below, so the result is only presented while the requester holds start.
   always_comb begin
      ready_d  = DivResultNotReady;
      result_d = '0;
      if (state == DivEnd && bus.start_i == DivStart) begin
         ready_d  = DivResultReady;
         result_d = result_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         cnt         <= '0;
         quo_reg     <= '0;
         rem_reg     <= '0;
         divisor_reg <= '0;
         signed_reg  <= 1'b0;
         op1_neg     <= 1'b0;
         op2_neg     <= 1'b0;
         result_reg  <= '0;
         ready_q     <= DivResultNotReady;
         result_q    <= '0;
      end else begin
         ready_q  <= ready_d;
         result_q <= result_d;
         case (state)
            DivFree: begin
               if (accept) begin
                  signed_reg  <= bus.signed_div_i;
                  op1_neg     <= bus.opdata1_i[31];
                  op2_neg     <= bus.opdata2_i[31];
                  quo_reg     <= magnitude(bus.opdata1_i, bus.signed_div_i);
                  divisor_reg <= magnitude(bus.opdata2_i, bus.signed_div_i);
                  rem_reg     <= '0;
                  cnt         <= '0;
               end
            end
            DivByZero: begin
               cnt <= '0;
               if (!bus.annul_i) begin
                  result_reg <= '0;
               end
            end
            DivOn: begin
               if (bus.annul_i) begin
                  cnt <= '0;
               end else if (cnt != IterCount) begin
                  cnt <= cnt + 6'd1;
                  // A borrow out of the trial subtraction means the divisor did not fit.
                  if (diff[32]) begin
                     rem_reg <= partial;
                     quo_reg <= {quo_reg[30:0], 1'b0};
                  end else begin
                     rem_reg <= diff[31:0];
                     quo_reg <= {quo_reg[30:0], 1'b1};
                  end
               end else begin
                  result_reg <= {rem_fix, quo_fix};
                  cnt        <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.ready_o  = ready_q;
   assign bus.result_o = result_q;

endmodule
